mesi_snoop_ctrl: RTL and testbench
==================================

// Module: mesi_snoop_ctrl
// PURPOSE
// - Bus-side (snooping) MESI controller for a whole cache: NUM_LINES direct-mapped lines, tag-matched.
// - Owns the coherence state of each line; processor-side controller installs/updates lines via upd_* port.
// - Sits between the shared bus and the local cache; on a snoop hit to a Modified line it aborts memory and runs a write-back handshake.
// PARAMETERS
// - NUM_LINES  4  number of lines (power of two, >=2); IDX_W = $clog2(NUM_LINES)
// - TAG_W      8  tag width compared against snoop_tag
// PORTS
// - CLK            in   1      clock; all logic on posedge
// - CLR            in   1      synchronous active-high reset
// - snoop_valid    in   1      bus transaction present; accepted when snoop_valid & snoop_ready
// - snoop_op       in   2      00 none, 01 BusRd (read miss), 10 BusRdX (write miss), 11 BusInv (invalidate)
// - snoop_idx      in   IDX_W  line index of bus address
// - snoop_tag      in   TAG_W  tag of bus address
// - snoop_ready    out  1      controller can accept a snoop (low during write-back)
// - upd_valid      in   1      processor-side state write
// - upd_idx        in   IDX_W  line to write
// - upd_tag        in   TAG_W  tag to store
// - upd_state      in   3      new state (001 I, 010 S, 011 E, 100 M)
// - upd_retry      out  1      upd write dropped this cycle; source must repeat it
// - abort_mem      out  1      tells memory to abandon the current bus access
// - wb_req         out  1      write-back request; held until wb_ack
// - wb_idx         out  IDX_W  line being written back
// - wb_tag         out  TAG_W  tag being written back
// - wb_ack         in   1      write-back complete
// - line_state     out  3*NUM_LINES  packed current state, line i at [3*i+:3]
// BEHAVIOUR
// - Reset (CLR=1 at posedge): all lines I (3'b001), tags 0, FSM IDLE; snoop_ready=1, upd_retry=0, abort_mem=0, wb_req=0, wb_idx=0, wb_tag=0.
// - Hit = line_state[snoop_idx]!=I && stored tag==snoop_tag; miss or op 00 -> no change.
// - FSM IDLE (snoop_ready=1), accepted hit, next state registered same edge (1-cycle latency):
//   S: BusRd->S; BusRdX->I; BusInv->I.   E: BusRd->S; BusRdX->I; BusInv->I.
//   M: BusInv->I; BusRd or BusRdX -> go WB, line stays M, latch pending op.
// - FSM WB: snoop_ready=0, abort_mem=1, wb_req=1, wb_idx/wb_tag = hit line; outputs stable until wb_ack.
//   Cycle wb_ack=1 seen: line -> S (pending BusRd) or I (pending BusRdX); next cycle IDLE, abort_mem=0, wb_req=0.
//   wb_ack outside WB ignored; wb_ack in the first WB cycle is legal (min write-back 2 cycles total).
// - upd port: written on posedge when upd_valid; illegal upd_state codes (000,101-111) ignored.
// - Simultaneous snoop hit and upd to same idx in IDLE: snoop wins, upd dropped, upd_retry=1 (combinational, same cycle).
// - In WB: upd to wb_idx dropped with upd_retry=1; upd to other lines proceeds.
// - Different idx same cycle: both applied.
// - CLR during WB: immediate return to reset state; write-back abandoned, wb_req drops next edge.
// CONFIGURATION
// - MESI_SHARED_LINE_EN defined: extra output snoop_shared (1 bit), combinational = snoop_valid & snoop_ready & hit & op==BusRd, so the requester installs S instead of E.
// - Not defined: port absent; requester always assumes no sharer.
// STRUCTURE
// - Package mesi_pkg: state localparams ST_I/ST_S/ST_E/ST_M (3'b001..3'b100), snoop op codes OP_NONE/OP_RD/OP_RDX/OP_INV, FSM encodings.
// - Sub-module mesi_snoop_lookup: combinational tag compare + state read for one index -> hit, hit_state.
// - Top holds state/tag arrays, FSM, update arbitration.
// TESTING
// - CLR, then upd idx2 tag 8'h5A state E; snoop BusRd idx2 tag 5A -> line2 = S next cycle, wb_req stays 0.
// - Line1 M tag 8'h11; snoop BusRdX idx1 tag 11 -> snoop_ready=0, abort_mem=1, wb_req=1, wb_idx=1, wb_tag=11; wb_ack after 3 cycles -> line1 I, ready=1.
// - Line3 S tag 8'h20; snoop BusInv idx3 tag 21 -> miss, line3 stays S; tag 20 -> line3 I.
// - Same cycle snoop BusRdX hit idx0 (E) and upd idx0 state M -> upd_retry=1, line0 I; repeated upd next cycle -> line0 M.
// - During WB of line1, upd idx1 -> retry=1; upd idx2 state S -> line2 S; CLR mid-WB -> all lines I, wb_req=0.
// - MESI_SHARED_LINE_EN: line0 E, snoop BusRd hit -> snoop_shared=1; miss -> 0; BusRdX hit -> 0.

Source files
------------

// File: rtl/mesi_pkg.sv
// mesi_pkg: shared encodings for the MESI snooping controller.
//   ST_*   : per-line coherence state codes (one-hot-ish, 3 bits, 000 and
//            101-111 are illegal and never stored)
//   OP_*   : bus snoop op codes
//   fsm_e  : controller FSM encoding
//   state_legal() : filters processor-side state writes
package mesi_pkg;

  localparam logic [2:0] ST_I = 3'b001;
  localparam logic [2:0] ST_S = 3'b010;
  localparam logic [2:0] ST_E = 3'b011;
  localparam logic [2:0] ST_M = 3'b100;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_RDX  = 2'b10;
  localparam logic [1:0] OP_INV  = 2'b11;

  typedef enum logic {
    FSM_IDLE = 1'b0,
    FSM_WB   = 1'b1
  } fsm_e;

  function automatic logic state_legal(input logic [2:0] s);
    return (s == ST_I) || (s == ST_S) || (s == ST_E) || (s == ST_M);
  endfunction

endpackage

// File: rtl/mesi_snoop_lookup.sv
// mesi_snoop_lookup: combinational tag compare for the line selected by the
// snoop index.
//   line_state_i : stored state of the indexed line
//   line_tag_i   : stored tag of the indexed line
//   snoop_tag_i  : tag of the bus address
//   hit_o        : line valid (not I) and tag matches
//   hit_state_o  : stored state, meaningful only when hit_o
module mesi_snoop_lookup
  import mesi_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic [2:0]       line_state_i,
  input  logic [TAG_W-1:0] line_tag_i,
  input  logic [TAG_W-1:0] snoop_tag_i,
  output logic             hit_o,
  output logic [2:0]       hit_state_o
);

  assign hit_o       = (line_state_i != ST_I) && (line_tag_i == snoop_tag_i);
  assign hit_state_o = line_state_i;

endmodule

// File: rtl/mesi_snoop_ctrl.sv
// mesi_snoop_ctrl: bus-side MESI controller for a direct-mapped cache of
// NUM_LINES tag-matched lines.
//   CLK, CLR          : clock, synchronous active-high reset
//   snoop_*           : bus snoop request (valid/ready handshake, op, idx, tag)
//   upd_*             : processor-side state/tag write, upd_retry when dropped
//   abort_mem, wb_*   : write-back handshake raised on a snoop hit to M
//   line_state        : packed per-line state, line i at [3*i+:3]
// Optional feature macro: MESI_SHARED_LINE_EN adds output snoop_shared, high
// when an accepted BusRd hits a valid line so the requester installs S.
module mesi_snoop_ctrl
  import mesi_pkg::*;
#(
  parameter  int NUM_LINES = 4,
  parameter  int TAG_W     = 8,
  localparam int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic                   CLK,
  input  logic                   CLR,
  input  logic                   snoop_valid,
  input  logic [1:0]             snoop_op,
  input  logic [IDX_W-1:0]       snoop_idx,
  input  logic [TAG_W-1:0]       snoop_tag,
  output logic                   snoop_ready,
  input  logic                   upd_valid,
  input  logic [IDX_W-1:0]       upd_idx,
  input  logic [TAG_W-1:0]       upd_tag,
  input  logic [2:0]             upd_state,
  output logic                   upd_retry,
  output logic                   abort_mem,
  output logic                   wb_req,
  output logic [IDX_W-1:0]       wb_idx,
  output logic [TAG_W-1:0]       wb_tag,
  input  logic                   wb_ack,
`ifdef MESI_SHARED_LINE_EN
  output logic                   snoop_shared,
`endif
  output logic [3*NUM_LINES-1:0] line_state
);

  logic [NUM_LINES-1:0][2:0]       state_q, state_d;
  logic [NUM_LINES-1:0][TAG_W-1:0] tag_q, tag_d;
  fsm_e                            fsm_q, fsm_d;
  logic [IDX_W-1:0]                wb_idx_q, wb_idx_d;
  logic [TAG_W-1:0]                wb_tag_q, wb_tag_d;
  logic                            pend_rdx_q, pend_rdx_d;

  logic       hit;
  logic [2:0] hit_state;
  logic       snoop_acc;
  logic       upd_conflict;

  mesi_snoop_lookup #(.TAG_W(TAG_W)) u_lookup (
    .line_state_i (state_q[snoop_idx]),
    .line_tag_i   (tag_q[snoop_idx]),
    .snoop_tag_i  (snoop_tag),
    .hit_o        (hit),
    .hit_state_o  (hit_state)
  );

  assign snoop_ready = (fsm_q == FSM_IDLE);
  assign snoop_acc   = snoop_valid && snoop_ready && hit && (snoop_op != OP_NONE);

  // The snoop owns the line it touches: in IDLE the accepted snoop's line,
  // in WB the line being written back. A colliding upd is dropped whole.
  assign upd_conflict = upd_valid &&
                        ((snoop_acc && (upd_idx == snoop_idx)) ||
                         ((fsm_q == FSM_WB) && (upd_idx == wb_idx_q)));
  assign upd_retry    = upd_conflict;

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    fsm_d      = fsm_q;
    wb_idx_d   = wb_idx_q;
    wb_tag_d   = wb_tag_q;
    pend_rdx_d = pend_rdx_q;

    if (upd_valid && !upd_conflict && state_legal(upd_state)) begin
      state_d[upd_idx] = upd_state;
      tag_d[upd_idx]   = upd_tag;
    end

    case (fsm_q)
      FSM_IDLE: begin
        if (snoop_acc) begin
          if ((hit_state == ST_M) && (snoop_op != OP_INV)) begin
            // Dirty data must reach memory first; line stays M until ack.
            fsm_d      = FSM_WB;
            wb_idx_d   = snoop_idx;
            wb_tag_d   = snoop_tag;
            pend_rdx_d = (snoop_op == OP_RDX);
          end else begin
            state_d[snoop_idx] = (snoop_op == OP_RD) ? ST_S : ST_I;
          end
        end
      end
      FSM_WB: begin
        if (wb_ack) begin
          state_d[wb_idx_q] = pend_rdx_q ? ST_I : ST_S;
          fsm_d             = FSM_IDLE;
        end
      end
      default: fsm_d = FSM_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q    <= {NUM_LINES{ST_I}};
      tag_q      <= '0;
      fsm_q      <= FSM_IDLE;
      wb_idx_q   <= '0;
      wb_tag_q   <= '0;
      pend_rdx_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      fsm_q      <= fsm_d;
      wb_idx_q   <= wb_idx_d;
      wb_tag_q   <= wb_tag_d;
      pend_rdx_q <= pend_rdx_d;
    end
  end

  assign abort_mem  = (fsm_q == FSM_WB);
  assign wb_req     = (fsm_q == FSM_WB);
  assign wb_idx     = wb_idx_q;
  assign wb_tag     = wb_tag_q;
  assign line_state = state_q;

`ifdef MESI_SHARED_LINE_EN
  assign snoop_shared = snoop_valid && snoop_ready && hit && (snoop_op == OP_RD);
`endif

endmodule

// File: tb/tb_mesi_snoop_ctrl.sv
// Self-checking bench for mesi_snoop_ctrl: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// line-table reference model.
module tb_mesi_snoop_ctrl;

  localparam int N = 4;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic       snoop_valid = 1'b0;
  logic [1:0] snoop_op = 2'b00;
  logic [1:0] snoop_idx = '0;
  logic [7:0] snoop_tag = '0;
  logic       snoop_ready;
  logic       upd_valid = 1'b0;
  logic [1:0] upd_idx = '0;
  logic [7:0] upd_tag = '0;
  logic [2:0] upd_state = 3'b001;
  logic       upd_retry;
  logic       abort_mem;
  logic       wb_req;
  logic [1:0] wb_idx;
  logic [7:0] wb_tag;
  logic       wb_ack = 1'b0;
  logic [11:0] line_state;
`ifdef MESI_SHARED_LINE_EN
  logic       snoop_shared;
`endif

  mesi_snoop_ctrl #(.NUM_LINES(N), .TAG_W(8)) dut (
    .CLK(CLK), .CLR(CLR),
    .snoop_valid(snoop_valid), .snoop_op(snoop_op), .snoop_idx(snoop_idx),
    .snoop_tag(snoop_tag), .snoop_ready(snoop_ready),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_tag(upd_tag),
    .upd_state(upd_state), .upd_retry(upd_retry),
    .abort_mem(abort_mem), .wb_req(wb_req), .wb_idx(wb_idx), .wb_tag(wb_tag),
    .wb_ack(wb_ack),
`ifdef MESI_SHARED_LINE_EN
    .snoop_shared(snoop_shared),
`endif
    .line_state(line_state)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: a table of lines plus a WB flag -------
  logic [2:0] m_st  [N];
  logic [7:0] m_tag [N];
  bit         m_wb;
  logic [1:0] m_wbidx;
  logic [7:0] m_wbtag;
  bit         m_pend_rdx;
  bit         model_ok = 0;

  function automatic bit legal(input logic [2:0] s);
    return s inside {3'b001, 3'b010, 3'b011, 3'b100};
  endfunction

  function automatic bit m_hit();
    return snoop_valid && !m_wb && snoop_op != 2'b00 &&
           m_st[snoop_idx] != 3'b001 && m_tag[snoop_idx] == snoop_tag;
  endfunction

  function automatic bit m_retry();
    if (!upd_valid) return 0;
    if (!m_wb) return m_hit() && upd_idx == snoop_idx;
    return upd_idx == m_wbidx;
  endfunction

  function automatic logic [11:0] m_pack();
    logic [11:0] v;
    for (int i = 0; i < N; i++) v[3*i +: 3] = m_st[i];
    return v;
  endfunction

  task automatic model_step();
    bit hit, retry, was_wb;
    hit = m_hit();
    retry = m_retry();
    was_wb = m_wb;
    if (CLR) begin
      for (int i = 0; i < N; i++) begin m_st[i] = 3'b001; m_tag[i] = 8'h00; end
      m_wb = 0; m_wbidx = 0; m_wbtag = 0; m_pend_rdx = 0;
      model_ok = 1;
      return;
    end
    if (upd_valid && !retry && legal(upd_state)) begin
      m_st[upd_idx] = upd_state;
      m_tag[upd_idx] = upd_tag;
    end
    if (hit) begin
      if (m_st[snoop_idx] == 3'b100 && snoop_op != 2'b11) begin
        m_wb = 1; m_wbidx = snoop_idx; m_wbtag = snoop_tag;
        m_pend_rdx = (snoop_op == 2'b10);
      end else begin
        m_st[snoop_idx] = (snoop_op == 2'b01) ? 3'b010 : 3'b001;
      end
    end
    if (was_wb && wb_ack) begin
      m_st[m_wbidx] = m_pend_rdx ? 3'b001 : 3'b010;
      m_wb = 0;
    end
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  // One compare process: every cycle, mid-period, outputs vs model.
  initial forever begin
    @(negedge CLK);
    if (model_ok) begin
      chk("snoop_ready", snoop_ready, !m_wb);
      chk("abort_mem",   abort_mem,   m_wb);
      chk("wb_req",      wb_req,      m_wb);
      chk("wb_idx",      wb_idx,      m_wbidx);
      chk("wb_tag",      wb_tag,      m_wbtag);
      chk("upd_retry",   upd_retry,   m_retry());
      chk("line_state",  line_state,  m_pack());
`ifdef MESI_SHARED_LINE_EN
      chk("snoop_shared", snoop_shared, m_hit() && snoop_op == 2'b01);
`endif
    end
  end

  // ---------------- stimulus ---------------------------------------------
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    snoop_valid = 0; snoop_op = 2'b00; upd_valid = 0; wb_ack = 0; CLR = 0;
  endtask

  task automatic upd(input logic [1:0] i, input logic [7:0] t, input logic [2:0] s);
    upd_valid = 1; upd_idx = i; upd_tag = t; upd_state = s;
  endtask

  task automatic snoop(input logic [1:0] op, input logic [1:0] i, input logic [7:0] t);
    snoop_valid = 1; snoop_op = op; snoop_idx = i; snoop_tag = t;
  endtask

  logic [7:0] tagset [4] = '{8'h11, 8'h5A, 8'h20, 8'h33};

  initial begin
    #2;
    CLR = 1; cyc(); idle_inputs();
    chk("reset line_state", line_state, 12'h249);
    chk("reset ready", snoop_ready, 1'b1);
    chk("reset wb_req", wb_req, 1'b0);
    chk("reset wb_idx/tag", {wb_idx, wb_tag}, 10'h000);

    // E line, BusRd hit -> S, no write-back
    upd(2, 8'h5A, 3'b011); cyc(); idle_inputs();
    snoop(2'b01, 2, 8'h5A); cyc(); idle_inputs();
    chk("E BusRd -> S", line_state[8:6], 3'b010);
    chk("E BusRd no wb", wb_req, 1'b0);

    // M line, BusRdX -> write-back, ack on third WB cycle -> I
    upd(1, 8'h11, 3'b100); cyc(); idle_inputs();
    snoop(2'b10, 1, 8'h11); cyc(); idle_inputs();
    chk("WB ready", snoop_ready, 1'b0);
    chk("WB abort", abort_mem, 1'b1);
    chk("WB req/idx/tag", {wb_req, wb_idx, wb_tag}, {1'b1, 2'd1, 8'h11});
    chk("WB line still M", line_state[5:3], 3'b100);
    cyc(); cyc();
    wb_ack = 1; cyc(); idle_inputs();
    chk("after RdX wb line I", line_state[5:3], 3'b001);
    chk("after wb ready", snoop_ready, 1'b1);

    // BusInv with tag miss, then hit
    upd(3, 8'h20, 3'b010); cyc(); idle_inputs();
    snoop(2'b11, 3, 8'h21); cyc(); idle_inputs();
    chk("Inv miss keeps S", line_state[11:9], 3'b010);
    snoop(2'b11, 3, 8'h20); cyc(); idle_inputs();
    chk("Inv hit -> I", line_state[11:9], 3'b001);

    // same-cycle snoop and upd to one index: snoop wins
    upd(0, 8'h33, 3'b011); cyc(); idle_inputs();
    snoop(2'b10, 0, 8'h33); upd(0, 8'h33, 3'b100); #1;
    chk("collide retry", upd_retry, 1'b1);
    cyc(); snoop_valid = 0; snoop_op = 2'b00;
    chk("collide line0 I", line_state[2:0], 3'b001);
    #1 chk("repeat no retry", upd_retry, 1'b0);
    cyc(); idle_inputs();
    chk("repeat upd -> M", line_state[2:0], 3'b100);

    // upd during WB, then CLR mid-WB
    upd(1, 8'h11, 3'b100); cyc(); idle_inputs();
    snoop(2'b01, 1, 8'h11); cyc(); idle_inputs();
    upd(1, 8'h11, 3'b010); #1;
    chk("WB upd same idx retry", upd_retry, 1'b1);
    upd(2, 8'h44, 3'b010); #1;
    chk("WB upd other idx ok", upd_retry, 1'b0);
    cyc(); idle_inputs();
    chk("WB other line S", line_state[8:6], 3'b010);
    chk("still in WB", wb_req, 1'b1);
    CLR = 1; cyc(); idle_inputs();
    chk("CLR mid-WB lines", line_state, 12'h249);
    chk("CLR mid-WB wb_req", wb_req, 1'b0);

`ifdef MESI_SHARED_LINE_EN
    upd(0, 8'h77, 3'b011); cyc(); idle_inputs();
    snoop(2'b01, 0, 8'h77); #1 chk("shared hit Rd", snoop_shared, 1'b1);
    snoop(2'b01, 0, 8'h78); #1 chk("shared miss", snoop_shared, 1'b0);
    snoop(2'b10, 0, 8'h77); #1 chk("shared RdX", snoop_shared, 1'b0);
    idle_inputs(); cyc();
`endif

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      snoop_valid = ($urandom_range(0, 1) == 1);
      snoop_op    = 2'($urandom_range(0, 3));
      snoop_idx   = 2'($urandom_range(0, 3));
      snoop_tag   = tagset[$urandom_range(0, 3)];
      upd_valid   = ($urandom_range(0, 2) == 0);
      upd_idx     = 2'($urandom_range(0, 3));
      upd_tag     = tagset[$urandom_range(0, 3)];
      upd_state   = 3'($urandom_range(0, 7));
      wb_ack      = ($urandom_range(0, 2) == 0);
      CLR         = ($urandom_range(0, 199) == 0);
      cyc();
    end
    idle_inputs();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
